// File: rtl/vector_pkg.sv
// Shared constants and types for the vector load path.
// Also provides the per-lane address step helper.
package vector_pkg;

    localparam int LANES      = 16;
    localparam int LANE_W     = 8;
    localparam int ADDR_W     = 12;
    localparam int VEC_W      = LANES * LANE_W;
    localparam int LANE_IDX_W = 4;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } vload_state_t;

    localparam lane_idx_t LAST_LANE = 4'd15;

    // Address of the next lane; wraps modulo the data-memory size.
    function automatic logic [ADDR_W-1:0] next_lane_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] step
    );
        return addr + step;
    endfunction

endpackage

// File: rtl/vector_load_unit_if.sv
// Byte-wide data-memory read port used by the vector load unit.
// master = load unit (requester), slave = memory/arbiter side.
interface vector_load_unit_if;
    import vector_pkg::*;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [LANE_W-1:0] mem_rdata;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_gnt,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_gnt,
        output mem_rdata
    );

endinterface

// File: rtl/vector_lane_assembler.sv
// Lane-indexed byte writes into a 128-bit assembly buffer plus the committed vector register.
// The commit sees the buffer including a capture happening on the same edge.
module vector_lane_assembler
    import vector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  lane_idx_t         cap_lane,
    input  logic [LANE_W-1:0] cap_data,
    input  logic              commit,
    output logic [VEC_W-1:0]  vector_out
);

    logic [VEC_W-1:0] buf_r;
    logic [VEC_W-1:0] buf_next_s;
    logic [VEC_W-1:0] vec_r;

    // Merge the pending byte into its lane.
    always_comb begin
        buf_next_s = buf_r;
        if (cap_en) begin
            buf_next_s[cap_lane*LANE_W +: LANE_W] = cap_data;
        end else begin
            buf_next_s = buf_r;
        end
    end

    // Assembly buffer and committed vector registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_r <= {VEC_W{1'b0}};
            vec_r <= {VEC_W{1'b0}};
        end else begin
            buf_r <= buf_next_s;
            if (commit) begin
                vec_r <= buf_next_s;
            end
        end
    end

    assign vector_out = vec_r;

endmodule

// File: rtl/vector_load_unit.sv
// Gathers LANES consecutive (or strided) bytes from data memory into one vector.
// Optional macro VLOAD_STRIDE_EN adds a per-load stride input; otherwise stride is 1.
module vector_load_unit
    import vector_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
`ifdef VLOAD_STRIDE_EN
    input  logic [ADDR_W-1:0]     stride,
`endif
    vector_load_unit_if.master    mem,
    output logic                  busy,
    output logic                  done,
    output logic [VEC_W-1:0]      vector_out
);

    vload_state_t      state_r;
    vload_state_t      next_state_s;

    logic              rd_en_r;
    logic              rd_en_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [ADDR_W-1:0] stride_r;
    logic [ADDR_W-1:0] stride_nxt_s;
    logic [ADDR_W-1:0] stride_in_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              done_r;
    logic              done_nxt_s;
    lane_idx_t         lane_r;
    lane_idx_t         lane_nxt_s;
    logic              pend_r;
    logic              pend_nxt_s;
    lane_idx_t         pend_lane_r;
    lane_idx_t         pend_lane_nxt_s;
    logic              commit_s;
    logic              gnt_fire_s;

`ifdef VLOAD_STRIDE_EN
    assign stride_in_s = stride;
`else
    assign stride_in_s = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

    assign gnt_fire_s = (state_r == REQ) && mem.mem_gnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (gnt_fire_s && (lane_r == LAST_LANE)) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = REQ;
                end
            end
            DRAIN:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output/datapath next values; outputs are registered below.
    always_comb begin
        rd_en_nxt_s     = rd_en_r;
        addr_nxt_s      = addr_r;
        stride_nxt_s    = stride_r;
        busy_nxt_s      = busy_r;
        done_nxt_s      = 1'b0;
        lane_nxt_s      = lane_r;
        pend_nxt_s      = 1'b0;
        pend_lane_nxt_s = pend_lane_r;
        commit_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    rd_en_nxt_s  = 1'b1;
                    addr_nxt_s   = base_addr;
                    stride_nxt_s = stride_in_s;
                    busy_nxt_s   = 1'b1;
                    lane_nxt_s   = 4'd0;
                end else begin
                    rd_en_nxt_s  = 1'b0;
                    busy_nxt_s   = 1'b0;
                end
            end
            REQ: begin
                if (gnt_fire_s) begin
                    pend_nxt_s      = 1'b1;
                    pend_lane_nxt_s = lane_r;
                    lane_nxt_s      = lane_r + 4'd1;
                    addr_nxt_s      = next_lane_addr(addr_r, stride_r);
                    if (lane_r == LAST_LANE) begin
                        rd_en_nxt_s = 1'b0;
                    end else begin
                        rd_en_nxt_s = 1'b1;
                    end
                end else begin
                    rd_en_nxt_s = 1'b1;
                end
            end
            DRAIN: begin
                // Final lane is captured on this same edge, so the commit sees a full buffer.
                commit_s    = 1'b1;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b1;
                rd_en_nxt_s = 1'b0;
            end
            default: begin
                rd_en_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Registered outputs and load context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_r     <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            stride_r    <= {ADDR_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            lane_r      <= 4'd0;
            pend_r      <= 1'b0;
            pend_lane_r <= 4'd0;
        end else begin
            rd_en_r     <= rd_en_nxt_s;
            addr_r      <= addr_nxt_s;
            stride_r    <= stride_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            lane_r      <= lane_nxt_s;
            pend_r      <= pend_nxt_s;
            pend_lane_r <= pend_lane_nxt_s;
        end
    end

    vector_lane_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (pend_r),
        .cap_lane   (pend_lane_r),
        .cap_data   (mem.mem_rdata),
        .commit     (commit_s),
        .vector_out (vector_out)
    );

    assign mem.mem_rd_en = rd_en_r;
    assign mem.mem_addr  = addr_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench for vector_load_unit: table of loads plus reset-abort sequence.
// Expected vectors are queued at start and compared when done pulses.
module tb_vector_load_unit;
    import vector_pkg::*;

    typedef struct {
        logic [11:0]  base;
        logic [11:0]  stride;
        logic [127:0] exp;
        int           stall_k;
        int           stall_n;
        int           lat;
        bit           poke;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [11:0]  base_addr;
    logic [11:0]  stride_in;
    logic         busy;
    logic         done;
    logic [127:0] vector_out;

    logic [7:0]   mem [0:4095];
    logic [127:0] sb [$];
    logic [127:0] last_vec;
    logic         prev_done;
    int           n_checks;
    int           n_errors;
    int           n_pushed;
    int           n_done;
    vec_t         tbl [$];

    vector_load_unit_if mif ();

    vector_load_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
`ifdef VLOAD_STRIDE_EN
        .stride     (stride_in),
`endif
        .mem        (mif),
        .busy       (busy),
        .done       (done),
        .vector_out (vector_out)
    );

    always #5 clk = ~clk;

    // Memory model: data one cycle after a granted request, noise otherwise.
    always @(posedge clk) begin
        if (mif.mem_rd_en && mif.mem_gnt) mif.mem_rdata <= mem[mif.mem_addr];
        else                              mif.mem_rdata <= 8'($urandom);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop the expected vector on every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("done_single_pulse", 128'(prev_done), 128'(1'b0));
            if (sb.size() == 0) begin
                check("unexpected_done", 128'(1'b1), 128'(1'b0));
            end else begin
                last_vec = sb.pop_front();
                check("vector_out", vector_out, last_vec);
            end
            n_done++;
        end
        prev_done = done;
    end

    task automatic run_load(input vec_t t);
        int  k, cyc, left;
        bit  fin;
        logic [11:0] ea;
        @(negedge clk);
        start = 1'b1; base_addr = t.base; stride_in = t.stride;
        sb.push_back(t.exp); n_pushed++;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_at_e0", 128'(busy), 128'(1'b1));
        k = 0; cyc = 0; left = t.stall_n; fin = 1'b0;
        while (!fin && cyc < 40) begin
            if (t.poke && cyc == 3) begin
                start = 1'b1; base_addr = 12'h555;
            end else begin
                start = 1'b0;
            end
            check("mem_rd_en", 128'(mif.mem_rd_en), 128'(k < 16));
            if (k < 16) begin
                ea = 12'(base_addr * 0 + t.base + 12'(k) * stride_in);
                check("mem_addr", 128'(mif.mem_addr), 128'(ea));
            end
            check("vector_hold", vector_out, last_vec);
            check("busy_during", 128'(busy), 128'(1'b1));
            if (k == t.stall_k && left > 0) begin
                mif.mem_gnt = 1'b0; left--;
            end else begin
                mif.mem_gnt = 1'b1;
                if (k < 16) k++;
            end
            @(posedge clk); #1;
            cyc++;
            if (done) fin = 1'b1;
        end
        start = 1'b0;
        mif.mem_gnt = 1'b1;
        check("done_seen", 128'(fin), 128'(1'b1));
        check("latency", 128'(cyc), 128'(t.lat));
        check("busy_after_commit", 128'(busy), 128'(1'b0));
    endtask

    function automatic vec_t mk(input logic [11:0] b, input logic [11:0] s, input logic [127:0] e,
                                input int sk, input int sn, input int lat, input bit poke);
        vec_t v;
        v.base = b; v.stride = s; v.exp = e; v.stall_k = sk; v.stall_n = sn; v.lat = lat; v.poke = poke;
        return v;
    endfunction

    initial begin
        n_checks = 0; n_errors = 0; n_pushed = 0; n_done = 0;
        last_vec = 128'd0; prev_done = 1'b0;
        rst = 1'b1; start = 1'b0; base_addr = 12'h000; stride_in = 12'h001;
        mif.mem_gnt = 1'b0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
        for (int i = 0; i < 16; i++) mem[12'h100 + i] = 8'(i + 1);

        tbl.push_back(mk(12'h100, 12'h001, 128'h100F0E0D0C0B0A090807060504030201, -1, 0, 17, 1'b0));
        tbl.push_back(mk(12'hFF8, 12'h001, 128'h0706050403020100FFFEFDFCFBFAF9F8, -1, 0, 17, 1'b0));
        tbl.push_back(mk(12'h100, 12'h001, 128'h100F0E0D0C0B0A090807060504030201,  5, 3, 20, 1'b0));
        tbl.push_back(mk(12'h200, 12'h001, 128'h0F0E0D0C0B0A09080706050403020100, -1, 0, 17, 1'b1));
        tbl.push_back(mk(12'h0F8, 12'h001, 128'h0807060504030201FFFEFDFCFBFAF9F8,  0, 1, 18, 1'b0));
        tbl.push_back(mk(12'h200, 12'h001, 128'h0F0E0D0C0B0A09080706050403020100, 15, 2, 19, 1'b0));
`ifdef VLOAD_STRIDE_EN
        tbl.push_back(mk(12'h010, 12'h004, 128'h4C4844403C3834302C2824201C181410, -1, 0, 17, 1'b0));
        tbl.push_back(mk(12'h010, 12'h000, {16{8'h10}},                          -1, 0, 17, 1'b0));
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_en",  128'(mif.mem_rd_en), 128'(1'b0));
        check("rst_addr",   128'(mif.mem_addr),  128'(12'h000));
        check("rst_busy",   128'(busy),          128'(1'b0));
        check("rst_done",   128'(done),          128'(1'b0));
        check("rst_vector", vector_out,          128'd0);
        @(negedge clk);
        rst = 1'b0;
        mif.mem_gnt = 1'b1;

        // Back-to-back loads: each next start lands in the previous done cycle.
        for (int i = 0; i < tbl.size(); i++) run_load(tbl[i]);

        // Reset in the middle of a load (after 9 grants) discards it.
        @(negedge clk);
        start = 1'b1; base_addr = 12'h300;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_rd_en",  128'(mif.mem_rd_en), 128'(1'b0));
        check("abort_addr",   128'(mif.mem_addr),  128'(12'h000));
        check("abort_busy",   128'(busy),          128'(1'b0));
        check("abort_done",   128'(done),          128'(1'b0));
        check("abort_vector", vector_out,          128'd0);
        last_vec = 128'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("abort_no_done", 128'(done), 128'(1'b0));
        end
        run_load(tbl[0]);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty",   128'(sb.size()), 128'd0);
        check("done_count", 128'(n_done),    128'(n_pushed));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vector_load_unit.md
Name: vector_load_unit

Overview:
- Read-side counterpart of the vector store path: gathers 16 consecutive bytes from byte-wide data memory into one 128-bit vector.
- Placed in the MEM stage beside the vector store loader; result feeds vector register-file writeback.
- Issues one byte read per granted cycle, assembles lanes, then commits the full vector with a one-cycle done pulse.

Parameters:
- LANES, 16, number of vector lanes / bytes per load
- LANE_W, 8, bits per lane
- ADDR_W, 12, data-memory address width
- VEC_W, LANES*LANE_W (128), vector width (derived, not overridable)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  load request; sampled only in IDLE
- base_addr  in  ADDR_W  byte address of lane 0; sampled with start
- mem_rd_en  out  1  memory read request
- mem_addr  out  ADDR_W  read address
- mem_gnt  in  1  arbiter grant; request consumed on edge where mem_rd_en && mem_gnt
- mem_rdata  in  LANE_W  read data, valid the cycle after a granted request
- busy  out  1  high from start acceptance until commit edge
- done  out  1  one-cycle pulse: vector_out newly committed
- vector_out  out  VEC_W  last committed vector; lane i = bits [8i+7:8i]

Behaviour:
- Reset (async, any state): state=IDLE, mem_rd_en=0, mem_addr=0, busy=0, done=0, vector_out=0, lane index=0, assembly buffer=0, pending-capture flag=0. Load in progress is discarded; no partial commit.
- States: IDLE, REQ, DRAIN.
- IDLE: start=1 at edge -> latch base_addr, index k=0, state=REQ, busy=1. start=0 -> stay.
- REQ: mem_rd_en=1, mem_addr=(base+k*stride) mod 2^ADDR_W (stride=1 without optional feature). Address held stable while mem_gnt=0. On granted edge: record lane k as pending, k++. If k was LANES-1, state=DRAIN.
- Capture: at edge following a granted request, buffer lane[pending] <= mem_rdata. At most one capture pending at a time.
- DRAIN: mem_rd_en=0; at next edge capture lane 15, vector_out <= complete buffer, done=1 for the following cycle, busy=0, state=IDLE.
- Latency with mem_gnt tied 1: start edge E0, grants E1..E16, commit E17; done high between E17 and E18. Each deasserted-grant cycle adds one cycle.
- Address wrap: base 0xFF8 -> addresses 0xFF8..0xFFF, 0x000..0x007; no error.
- start while busy: ignored, not queued. start in the done cycle: accepted (state is IDLE).
- vector_out unchanged during a load; updates only at commit edge.
- mem_rdata ignored when no capture pending.

Optional Feature:
- Macro VLOAD_STRIDE_EN.
- Defined: extra input stride [ADDR_W-1:0], sampled with start; lane k address = base + k*stride mod 2^ADDR_W; stride=0 broadcasts one byte to all lanes.
- Undefined: port absent, stride fixed 1; behaviour otherwise identical.

Decomposition:
- Shared package vector_pkg: LANES, LANE_W, VEC_W, ADDR_W constants; vload_state_t enum {IDLE, REQ, DRAIN}; lane index typedef (4 bits).
- One natural sub-module: vector_lane_assembler (lane-indexed byte write into 128-bit buffer plus commit register).

Test Plan:
- gnt=1, base=0x100, memory[0x100+i]=i+1 -> done at E17, vector_out=0x100F0E0D0C0B0A090807060504030201, busy high E0..E17.
- base=0xFF8, memory[a]=a[7:0] -> lanes 0..7 = 0xF8..0xFF, lanes 8..15 = 0x00..0x07.
- mem_gnt low for 3 cycles at k=5 -> mem_addr holds base+5, done delayed to E20, vector correct.
- start pulsed at E4 during load -> ignored; exactly one done; back-to-back start in done cycle -> second load commits 17 cycles later.
- rst asserted mid-load at k=9 -> all outputs 0 immediately; no done; next load correct.
- VLOAD_STRIDE_EN, base=0x010, stride=4 -> addresses 0x010,0x014..0x04C; stride=0 -> all lanes equal memory[0x010].
